// File: rtl/tt_accum_pkg.sv
// Shared opcode encoding, pin constants and parameter checks for the accumulating ALU tile.
package tt_accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  localparam int FLAG_CARRY = 4;
  localparam int FLAG_OVF   = 5;
  localparam int FLAG_ZERO  = 6;
  localparam int FLAG_SAT   = 7;

  function automatic bit acc_w_legal(input int w);
    return (w >= 8) && (w <= 32) && ((w % 8) == 0);
  endfunction

endpackage

// File: rtl/tt_edge_sync.sv
// Per-bit 2-flop synchroniser plus history flop; emits a one-cycle pulse on each rising edge.
module tt_edge_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] s3;

  // The history flop keeps running while en is low, so an edge seen then is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3 & {N{en}};

endmodule

// File: rtl/tt_accum_alu.sv
// Accumulating ALU on the Tiny Tapeout pin set: add/sub/load/clear with flags, byte-serial readout.
module tt_accum_alu
  import tt_accum_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NB    = ACC_W / 8;
  localparam int PTR_W = (NB > 1) ? $clog2(NB) : 1;

  if (!acc_w_legal(ACC_W)) begin : g_bad_acc_w
    $error("tt_accum_alu: ACC_W must be a multiple of 8 in 8..32");
  end

  logic [ACC_W-1:0] acc;
  logic [PTR_W-1:0] ptr;
  logic             carry;
  logic             ovf;
  logic             sat;

  logic             stb_ev;
  logic             rd_ev;
  op_e              opc;
  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [ACC_W-1:0] nxt_acc;
  logic             nxt_carry;
  logic             nxt_ovf;
  logic             nxt_sat;
  logic             unused_ok;

  tt_edge_sync #(.N(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .din   ({uio_in[3], uio_in[0]}),
    .rise  ({rd_ev, stb_ev})
  );

  // Opcode and operand are taken live in the event cycle; the host holds them stable.
  assign opc     = op_e'(uio_in[2:1]);
  assign operand = ACC_W'(ui_in);

  assign sum     = {1'b0, acc} + {1'b0, operand};
  assign diff    = {1'b0, acc} - {1'b0, operand};
  assign ovf_add = (acc[ACC_W-1] == operand[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign ovf_sub = (acc[ACC_W-1] != operand[ACC_W-1]) && (diff[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    nxt_acc   = acc;
    nxt_carry = carry;
    nxt_ovf   = ovf;
    nxt_sat   = sat;
    case (opc)
      OP_ADD: begin
        nxt_acc   = sum[ACC_W-1:0];
        nxt_carry = sum[ACC_W];
        nxt_ovf   = ovf_add;
        if ((SATURATE != 0) && sum[ACC_W]) begin
          nxt_acc = '1;
          nxt_sat = 1'b1;
        end
      end
      OP_SUB: begin
        nxt_acc   = diff[ACC_W-1:0];
        nxt_carry = diff[ACC_W];
        nxt_ovf   = ovf_sub;
        if ((SATURATE != 0) && diff[ACC_W]) begin
          nxt_acc = '0;
          nxt_sat = 1'b1;
        end
      end
      OP_LOAD: begin
        nxt_acc   = operand;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        nxt_sat   = 1'b0;
      end
      OP_CLR: begin
        nxt_acc   = '0;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        nxt_sat   = 1'b0;
      end
      default: ;
    endcase
  end

  // A strobe wins over a coincident rd_next: the pointer returns to the low byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      ptr   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      sat   <= 1'b0;
    end else if (stb_ev) begin
      acc   <= nxt_acc;
      carry <= nxt_carry;
      ovf   <= nxt_ovf;
      sat   <= nxt_sat;
      ptr   <= '0;
    end else if (rd_ev) begin
      ptr <= (ptr == PTR_W'(NB - 1)) ? '0 : ptr + 1'b1;
    end
  end

  assign uo_out = 8'(acc >> {ptr, 3'b000});

  always_comb begin
    uio_out             = 8'h00;
    uio_out[FLAG_CARRY] = carry;
    uio_out[FLAG_OVF]   = ovf;
    uio_out[FLAG_ZERO]  = (acc == '0);
    uio_out[FLAG_SAT]   = sat;
  end

  assign uio_oe    = UIO_OE_MASK;
  assign unused_ok = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_accum_alu.sv
// Bench for tt_accum_alu: three configurations, directed vectors, queue-based scoreboard.
module tb_tt_accum_alu;

  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_LD  = 2'b10;
  localparam logic [1:0] OPC_CLR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: ACC_W=16 wrap, DUT1: ACC_W=16 saturating, DUT2: ACC_W=8 wrap
  logic [7:0] ui_d  [3];
  logic [7:0] uio_d [3];
  logic [7:0] uo_o  [3];
  logic [7:0] uio_o [3];
  logic [7:0] oe_o  [3];

  tt_accum_alu #(.ACC_W(16), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_d[0]), .uio_in(uio_d[0]),
    .uo_out(uo_o[0]), .uio_out(uio_o[0]), .uio_oe(oe_o[0]));
  tt_accum_alu #(.ACC_W(16), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_d[1]), .uio_in(uio_d[1]),
    .uo_out(uo_o[1]), .uio_out(uio_o[1]), .uio_oe(oe_o[1]));
  tt_accum_alu #(.ACC_W(8), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_d[2]), .uio_in(uio_d[2]),
    .uo_out(uo_o[2]), .uio_out(uio_o[2]), .uio_oe(oe_o[2]));

  // ---------------- scoreboard ----------------
  // entry: {due_cycle[31:0], dut[1:0], uo[7:0], uio[7:0], oe[7:0]}
  logic [57:0] exp_q [$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  last_uo  [3];
  logic [7:0]  last_uio [3];

  task automatic push(input int due, input int d, input logic [7:0] uo,
                      input logic [7:0] uio, input string nm);
    logic [1:0] dd;
    dd = d[1:0];
    exp_q.push_back({due, dd, uo, uio, 8'hF0});
    name_q.push_back(nm);
  endtask

  // monitor: compares each entry on the negedge of the cycle it is due
  logic [57:0] mon_e;
  string       mon_nm;
  int          mon_d;
  logic [23:0] mon_act;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][57:26]) <= cyc) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_d  = int'(mon_e[25:24]);
      mon_act = {uo_o[mon_d], uio_o[mon_d], oe_o[mon_d]};
      total++;
      if (int'(mon_e[57:26]) != cyc || mon_act !== mon_e[23:0]) begin
        bad++;
        $display("FAIL %s: dut%0d cyc=%0d got uo=%h uio=%h oe=%h, want uo=%h uio=%h oe=%h",
                 mon_nm, mon_d, cyc, mon_act[23:16], mon_act[15:8], mon_act[7:0],
                 mon_e[23:16], mon_e[15:8], mon_e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Raise strobe and/or rd_next for 'hold' cycles; result due 3 negedges after the rise.
  task automatic pulse(input int d, input logic [1:0] opc, input logic [7:0] val,
                       input logic stb, input logic rd, input int hold,
                       input logic [7:0] euo, input logic [7:0] euio, input string nm);
    int k;
    @(negedge clk);
    k = cyc;
    ui_d[d]  = val;
    uio_d[d] = {4'b0000, rd, opc, stb};
    push(k + 2, d, last_uo[d], last_uio[d], {nm, "_pre"});
    push(k + 3, d, euo, euio, nm);
    last_uo[d]  = euo;
    last_uio[d] = euio;
    repeat (hold) @(negedge clk);
    uio_d[d][0] = 1'b0;
    uio_d[d][3] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic op(input int d, input logic [1:0] opc, input logic [7:0] val,
                    input logic [7:0] euo, input logic [7:0] euio, input string nm);
    pulse(d, opc, val, 1'b1, 1'b0, 1, euo, euio, nm);
  endtask

  task automatic rd(input int d, input logic [7:0] euo, input logic [7:0] euio, input string nm);
    pulse(d, OPC_ADD, ui_d[d], 1'b0, 1'b1, 1, euo, euio, nm);
  endtask

  task automatic expect_reset_all(input int dly, input string nm);
    for (int d = 0; d < 3; d++) begin
      push(cyc + dly, d, 8'h00, 8'h40, nm);
      last_uo[d]  = 8'h00;
      last_uio[d] = 8'h40;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ui_d[d]  = 8'h00;
      uio_d[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    expect_reset_all(1, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    expect_reset_all(1, "reset_release");
    @(negedge clk);

    // 16-bit wrap: first op latency, load/add, byte readout and wrap
    op(0, OPC_ADD, 8'h05, 8'h05, 8'h00, "add05");
    op(0, OPC_LD,  8'hFF, 8'hFF, 8'h00, "load_ff");
    op(0, OPC_ADD, 8'h02, 8'h01, 8'h00, "add02_0101");
    rd(0, 8'h01, 8'h00, "rd_hi_0101");
    rd(0, 8'h01, 8'h00, "rd_wrap_0101");
    op(0, OPC_LD,  8'hAB, 8'hAB, 8'h00, "load_ab");
    rd(0, 8'h00, 8'h00, "rd_hi_00ab");
    rd(0, 8'hAB, 8'h00, "rd_wrap_00ab");
    op(0, OPC_CLR, 8'h00, 8'h00, 8'h40, "clear");
    op(0, OPC_SUB, 8'h01, 8'hFF, 8'h10, "sub_borrow_ffff");
    rd(0, 8'hFF, 8'h10, "rd_hi_ffff");
    // strobe held 10 cycles: exactly one ADD 01 (FFFF -> 0000 with carry)
    pulse(0, OPC_ADD, 8'h01, 1'b1, 1'b0, 10, 8'h00, 8'h50, "held_strobe");
    push(cyc + 2, 0, 8'h00, 8'h50, "held_strobe_once");
    @(negedge clk);
    @(negedge clk);
    op(0, OPC_ADD, 8'h01, 8'h01, 8'h00, "add_after_held");
    op(0, OPC_LD,  8'h34, 8'h34, 8'h00, "load_34");
    rd(0, 8'h00, 8'h00, "rd_hi_0034");
    pulse(0, OPC_ADD, 8'h01, 1'b1, 1'b1, 1, 8'h35, 8'h00, "stb_and_rd");
    ena = 1'b0;
    op(0, OPC_ADD, 8'h10, 8'h35, 8'h00, "ena_low_no_op");
    ena = 1'b1;
    push(cyc + 2, 0, 8'h35, 8'h00, "ena_restored_no_op");
    @(negedge clk);
    @(negedge clk);

    // 16-bit saturating
    op(1, OPC_CLR, 8'h00, 8'h00, 8'h40, "sat_clear");
    op(1, OPC_SUB, 8'h01, 8'h00, 8'hD0, "sat_sub_clamp");
    op(1, OPC_ADD, 8'h03, 8'h03, 8'h80, "sat_sticky_add");
    op(1, OPC_LD,  8'h00, 8'h00, 8'h40, "sat_load_clears");
    op(1, OPC_LD,  8'h05, 8'h05, 8'h00, "sat_load_05");
    op(1, OPC_SUB, 8'h02, 8'h03, 8'h00, "sat_sub_noclamp");

    // 8-bit wrap: signed overflow and carry
    op(2, OPC_LD,  8'h7F, 8'h7F, 8'h00, "w8_load_7f");
    op(2, OPC_ADD, 8'h01, 8'h80, 8'h20, "w8_add_ovf");
    op(2, OPC_ADD, 8'h80, 8'h00, 8'h70, "w8_add_carry_ovf");
    rd(2, 8'h00, 8'h70, "w8_rd_single_byte");
    op(2, OPC_LD,  8'h5A, 8'h5A, 8'h00, "w8_load_5a");
    rd(2, 8'h5A, 8'h00, "w8_rd_wrap");

    // reset in the cycle after a strobe rise: op discarded, all outputs to reset values
    @(negedge clk);
    ui_d[0]  = 8'h01;
    uio_d[0] = {4'b0000, 1'b0, OPC_ADD, 1'b1};
    @(negedge clk);
    uio_d[0] = 8'h00;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_reset_all(1, "mid_reset");
    expect_reset_all(3, "mid_reset_no_op");
    repeat (6) @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      last_uo[d]  = 8'h00;
      last_uio[d] = 8'h40;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
